video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named sclk and s_rst_n.
REQ-002 The block SHALL provide the following parameters (name, default, meaning):
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- SYNC_POL, 1, 1 means sync pulses are active-high
REQ-003 The block SHALL provide the following ports (name, direction, width, meaning):
- sclk, in, 1, 74.25 MHz pixel clock
- s_rst_n, in, 1, async active-low reset
- enable, in, 1, level; request to start or keep pixel fetch
- fifo_empty, in, 1, RFIFO empty flag
- fifo_rd_data, in, 16, RGB565; valid the cycle after fifo_rd_en
- fifo_rd_en, out, 1, RFIFO read strobe
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, data enable
- rgb, out, 24, {R8,G8,B8}
- frame_start, out, 1, one-cycle pulse on first active pixel of each frame
- underflow_cnt, out, 16, count of reads issued while empty

Function
REQ-004 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP) and wrap to 0; v_cnt SHALL increment when h_cnt=H_TOTAL-1 and wrap to 0 after V_TOTAL-1.
REQ-005 Region order SHALL be active, front porch, sync, back porch. Counters SHALL run from reset regardless of state.
REQ-006 act SHALL be (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE). hs_raw SHALL be asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vs_raw SHALL use the same rule on v_cnt.
REQ-007 The FSM SHALL have states IDLE, WAIT_FRAME and RUN:
- IDLE->WAIT_FRAME when enable=1 && fifo_empty=0.
- WAIT_FRAME->RUN when h_cnt=H_TOTAL-1 && v_cnt=V_TOTAL-1.
- RUN->IDLE at that same frame-end point if enable=0.
- enable falling mid-frame SHALL NOT truncate the frame.
- WAIT_FRAME->IDLE if enable=0.
REQ-008 fifo_rd_en SHALL be (act && state==RUN), decoded from registered counters; exactly H_ACTIVE*V_ACTIVE reads SHALL occur per RUN frame.
REQ-009 de, hsync, vsync and frame_start SHALL be act, hs_raw, vs_raw and (h_cnt=0 && v_cnt=0) delayed by exactly 2 cycles. hsync and vsync SHALL be XORed with ~SYNC_POL.
REQ-010 rgb SHALL be registered from fifo_rd_data in the cycle after the read:
- R = {d[15:11], d[15:13]}
- G = {d[10:5], d[10:9]}
- B = {d[4:0], d[4:2]}
- Aligned with de.
REQ-011 rgb SHALL be 24'h0 whenever de=0, whenever de=1 outside RUN (timing keeps running with black pixels), and for any pixel whose read was issued with fifo_empty=1.
REQ-012 underflow_cnt SHALL increment by 1 per cycle with fifo_rd_en=1 && fifo_empty=1, and SHALL saturate at 16'hFFFF. The read strobe SHALL NOT be suppressed on underflow (pixel alignment is kept).
REQ-013 All outputs SHALL be registered except fifo_rd_en.

Reset
REQ-014 While s_rst_n=0, the following SHALL hold:
- h_cnt=0, v_cnt=0, state=IDLE
- fifo_rd_en=0, de=0, frame_start=0, rgb=0, underflow_cnt=0
- hsync and vsync at inactive level (0 when SYNC_POL=1)
- all pipeline registers cleared
REQ-015 Reset assertion mid-frame SHALL take effect asynchronously. After release, the first frame SHALL begin at h_cnt=0, v_cnt=0, with no read issued before RUN.

Verification (bench uses H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 unless stated)
REQ-016 enable=0, 3 frames -> fifo_rd_en never 1; de high 32 cycles/frame with rgb=0; hsync high 2 cycles per 14-cycle line; vsync high 14 cycles per 98-cycle frame.
REQ-017 enable=1, fifo_empty=0 mid-frame -> first fifo_rd_en at start of next frame; exactly 32 reads/frame; frame_start pulses 2 cycles after h_cnt=v_cnt=0.
REQ-018 fifo_rd_data=16'hF800 on every read -> rgb=24'hFF0000 during de; 16'h07E0 -> 24'h00FF00; 16'h001F -> 24'h0000FF; rgb registered 2 cycles after counter enters active.
REQ-019 fifo_empty forced 1 for 5 active cycles in RUN -> underflow_cnt=5; those 5 pixels black; following pixels correct and aligned; preloading underflow_cnt=16'hFFFE plus 3 underflows -> 16'hFFFF.
REQ-020 enable dropped at v_cnt=1 in RUN -> remaining reads of that frame still issued (32 total); no reads next frame.
REQ-021 s_rst_n pulsed low mid-line in RUN -> all outputs reach reset values immediately; after release state=IDLE and counters restart from 0.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle of the video timing generator: read-FIFO handshake on one
// side, synchronised video stream and status on the other.
interface video_timing_gen_if;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [23:0] rgb;
    logic        frame_start;
    logic [15:0] underflow_cnt;

    // Driver view: supplies enable and FIFO data, observes the video stream.
    modport master (
        output enable, fifo_empty, fifo_rd_data,
        input  fifo_rd_en, hsync, vsync, de, rgb, frame_start, underflow_cnt
    );

    // Generator view.
    modport slave (
        input  enable, fifo_empty, fifo_rd_data,
        output fifo_rd_en, hsync, vsync, de, rgb, frame_start, underflow_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// Video timing generator: free-running raster counters, a frame-aligned
// pixel-fetch FSM, and a two-stage output pipeline that lines up sync,
// data-enable and RGB888 expanded from RGB565 FIFO words.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | timing runs, no reads, black pixels
// S_WAIT_FRAME | start requested, waiting for the current frame to end
// S_RUN        | reading one FIFO word per active pixel
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int SYNC_POL = 1
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    video_timing_gen_if.slave vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One extra bit of headroom so the sync-end bound never aliases to zero.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Inverting term applied to raw syncs; also the idle sync level.
    localparam logic SYNC_INV = (SYNC_POL == 0);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_RUN        = 2'd2
    } state_t;

    state_t        state_q;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    logic act, hs_raw, vs_raw, fs_raw, h_last, frame_end, rd_en;

    logic act_p1_q, hs_p1_q, vs_p1_q, fs_p1_q, pix_ok_p1_q;
    logic de_q, hsync_q, vsync_q, frame_start_q;
    logic [23:0] rgb_q, rgb_d;
    logic [15:0] underflow_q, underflow_d;

    // Raster decode, all from registered counters.
    assign h_last    = (h_cnt_q == H_LAST);
    assign frame_end = h_last && (v_cnt_q == V_LAST);
    assign act       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_raw    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_raw    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    assign fs_raw    = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign rd_en     = act && (state_q == S_RUN);

    // Next raster position; v advances on the last pixel of each line.
    always_comb begin
        h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Raster counters run continuously, independent of the fetch state.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Fetch FSM: starts and stops only on frame boundaries so frames are whole.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (vif.enable && !vif.fifo_empty) state_q <= S_WAIT_FRAME;
                end
                S_WAIT_FRAME: begin
                    if (!vif.enable)    state_q <= S_IDLE;
                    else if (frame_end) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (frame_end && !vif.enable) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stage 1: timing flags, and whether this cycle's read returns a real pixel.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            act_p1_q    <= 1'b0;
            hs_p1_q     <= 1'b0;
            vs_p1_q     <= 1'b0;
            fs_p1_q     <= 1'b0;
            pix_ok_p1_q <= 1'b0;
        end else begin
            act_p1_q    <= act;
            hs_p1_q     <= hs_raw;
            vs_p1_q     <= vs_raw;
            fs_p1_q     <= fs_raw;
            pix_ok_p1_q <= rd_en && !vif.fifo_empty;
        end
    end

    // RGB565 -> RGB888 by replicating MSBs; black unless a good read is landing.
    always_comb begin
        rgb_d = 24'h0;
        if (pix_ok_p1_q) begin
            rgb_d = {vif.fifo_rd_data[15:11], vif.fifo_rd_data[15:13],
                     vif.fifo_rd_data[10:5],  vif.fifo_rd_data[10:9],
                     vif.fifo_rd_data[4:0],   vif.fifo_rd_data[4:2]};
        end
    end

    // Stage 2: registered outputs, two cycles behind the counters.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            de_q          <= 1'b0;
            hsync_q       <= SYNC_INV;
            vsync_q       <= SYNC_INV;
            frame_start_q <= 1'b0;
            rgb_q         <= 24'h0;
        end else begin
            de_q          <= act_p1_q;
            hsync_q       <= hs_p1_q ^ SYNC_INV;
            vsync_q       <= vs_p1_q ^ SYNC_INV;
            frame_start_q <= fs_p1_q;
            rgb_q         <= rgb_d;
        end
    end

    // Underflow count; the strobe itself is never held back so pixels stay aligned.
    always_comb begin
        underflow_d = underflow_q;
        if (rd_en && vif.fifo_empty && (underflow_q != 16'hFFFF)) begin
            underflow_d = underflow_q + 16'd1;
        end
    end

    // Saturating underflow counter register.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) underflow_q <= 16'h0;
        else          underflow_q <= underflow_d;
    end

    assign vif.fifo_rd_en    = rd_en;
    assign vif.de            = de_q;
    assign vif.hsync         = hsync_q;
    assign vif.vsync         = vsync_q;
    assign vif.frame_start   = frame_start_q;
    assign vif.rgb           = rgb_q;
    assign vif.underflow_cnt = underflow_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: random FIFO data/empty stimulus
// compared cycle by cycle against a raster-position reference model.
module tb_video_timing_gen;
    localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2;

    logic sclk = 1'b0;
    logic s_rst_n;
    always #5 sclk = ~sclk;

    video_timing_gen_if vif ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1)
    ) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .vif     (vif)
    );

    int n_chk = 0;
    int n_bad = 0;

    // reference model: raster position of the current cycle, fetch mode, history
    int          m_h, m_v, m_mode, cyc;
    logic [15:0] m_uf;
    logic        h_act[4], h_hs[4], h_vs[4], h_fs[4], h_pix[4];
    logic [15:0] h_data[4];

    // stimulus controls
    logic        drv_en, emp_random, data_const_en;
    logic [15:0] data_const;
    int          uf_inject;

    // observation counters
    int          rd_cnt, de_cnt, hs_cnt, vs_cnt, fs_cnt;
    logic [23:0] last_rgb;

    logic [15:0] pats[3]   = '{16'hF800, 16'h07E0, 16'h001F};
    logic [23:0] pat_exp[3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] expand565(input logic [15:0] d);
        int r, g, b;
        r = int'(d[15:11]);
        g = int'(d[10:5]);
        b = int'(d[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode = M_IDLE; cyc = 0; m_uf = 16'h0;
        for (int i = 0; i < 4; i++) begin
            h_act[i] = 1'b0; h_hs[i] = 1'b0; h_vs[i] = 1'b0;
            h_fs[i] = 1'b0;  h_pix[i] = 1'b0; h_data[i] = 16'h0;
        end
    endtask

    task automatic clear_obs();
        rd_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; last_rgb = 24'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_en"}, 32'(vif.fifo_rd_en),    32'd0);
        check_eq({tag, "_de"},    32'(vif.de),            32'd0);
        check_eq({tag, "_hsync"}, 32'(vif.hsync),         32'd0);
        check_eq({tag, "_vsync"}, 32'(vif.vsync),         32'd0);
        check_eq({tag, "_fs"},    32'(vif.frame_start),   32'd0);
        check_eq({tag, "_rgb"},   32'(vif.rgb),           32'd0);
        check_eq({tag, "_uf"},    32'(vif.underflow_cnt), 32'd0);
    endtask

    // Called at a falling edge: check this cycle, drive its inputs, advance the model.
    task automatic step();
        logic [1:0]  i0, i1, i2;
        logic        act, hs, vs, fs, rd, emp, fe;
        logic [15:0] data;
        logic [23:0] rgb_exp;
        i0 = cyc[1:0];
        i1 = i0 - 2'd1;
        i2 = i0 - 2'd2;
        act = (m_h < HA) && (m_v < VA);
        hs  = (m_h >= HA + HFP) && (m_h < HA + HFP + HS);
        vs  = (m_v >= VA + VFP) && (m_v < VA + VFP + VS);
        fs  = (m_h == 0) && (m_v == 0);
        rd  = act && (m_mode == M_RUN);
        rgb_exp = h_pix[i2] ? expand565(h_data[i1]) : 24'h0;

        check_eq("rd_en", 32'(vif.fifo_rd_en),    32'(rd));
        check_eq("de",    32'(vif.de),            32'(h_act[i2]));
        check_eq("hsync", 32'(vif.hsync),         32'(h_hs[i2]));
        check_eq("vsync", 32'(vif.vsync),         32'(h_vs[i2]));
        check_eq("fs",    32'(vif.frame_start),   32'(h_fs[i2]));
        check_eq("rgb",   32'(vif.rgb),           32'(rgb_exp));
        check_eq("uf",    32'(vif.underflow_cnt), 32'(m_uf));

        if (vif.fifo_rd_en)  rd_cnt++;
        if (vif.de)          begin de_cnt++; last_rgb = vif.rgb; end
        if (vif.hsync)       hs_cnt++;
        if (vif.vsync)       vs_cnt++;
        if (vif.frame_start) fs_cnt++;

        if (uf_inject > 0 && rd) begin
            emp = 1'b1;
            uf_inject--;
        end else if (emp_random) begin
            emp = 1'($urandom_range(0, 1));
        end else begin
            emp = 1'b0;
        end
        data = data_const_en ? data_const : 16'($urandom);
        vif.enable       = drv_en;
        vif.fifo_empty   = emp;
        vif.fifo_rd_data = data;

        h_act[i0] = act; h_hs[i0] = hs; h_vs[i0] = vs; h_fs[i0] = fs;
        h_pix[i0] = rd && !emp;
        h_data[i0] = data;
        if (rd && emp && m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;

        fe = (m_h == HT - 1) && (m_v == VT - 1);
        case (m_mode)
            M_IDLE:  if (drv_en && !emp) m_mode = M_ARMED;
            M_ARMED: if (!drv_en) m_mode = M_IDLE; else if (fe) m_mode = M_RUN;
            default: if (fe && !drv_en) m_mode = M_IDLE;
        endcase

        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
        cyc++;
        @(negedge sclk);
    endtask

    task automatic run_to_frame_start();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(m_h == 0 && m_v == 0) && n < 2 * FT);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        s_rst_n = 1'b0;
        drv_en = 1'b0; emp_random = 1'b0; data_const_en = 1'b0;
        data_const = 16'h0; uf_inject = 0;
        vif.enable = 1'b0; vif.fifo_empty = 1'b1; vif.fifo_rd_data = 16'h0;
        model_reset();
        clear_obs();
        repeat (2) @(negedge sclk);
        check_reset_outputs("por");
        s_rst_n = 1'b1;

        // enable low for three frames: timing only, black pixels
        emp_random = 1'b1;
        repeat (3 * FT) step();
        check_eq("idle_reads", 32'(rd_cnt), 32'd0);
        check_eq("idle_de",    32'(de_cnt), 32'(3 * HA * VA));
        check_eq("idle_hs",    32'(hs_cnt), 32'(3 * HS * VT));
        check_eq("idle_vs",    32'(vs_cnt), 32'(3 * VS * HT));
        check_eq("idle_fs",    32'(fs_cnt), 32'd3);

        // enable raised mid-frame: reads start only at the next frame
        emp_random = 1'b0;
        clear_obs();
        repeat (40) step();
        drv_en = 1'b1;
        run_to_frame_start();
        check_eq("rd_before_run", 32'(rd_cnt), 32'd0);
        clear_obs();
        repeat (FT) step();
        check_eq("run_reads", 32'(rd_cnt), 32'(HA * VA));
        check_eq("run_fs",    32'(fs_cnt), 32'd1);

        // pure-colour frames
        for (int p = 0; p < 3; p++) begin
            data_const_en = 1'b1;
            data_const = pats[p];
            clear_obs();
            repeat (FT) step();
            check_eq("pat_rgb",   32'(last_rgb), 32'(pat_exp[p]));
            check_eq("pat_reads", 32'(rd_cnt),   32'(HA * VA));
        end
        data_const_en = 1'b0;

        // five underflows inside RUN
        uf_inject = 5;
        repeat (FT) step();
        check_eq("uf_five", 32'(vif.underflow_cnt), 32'd5);

        // enable dropped on line 1 of a RUN frame
        clear_obs();
        for (int k = 0; k < FT; k++) begin
            if (m_v == 1 && m_h == 0) drv_en = 1'b0;
            step();
        end
        check_eq("drop_reads", 32'(rd_cnt), 32'(HA * VA));
        clear_obs();
        repeat (FT) step();
        check_eq("after_drop_reads", 32'(rd_cnt), 32'd0);

        // counter saturation from a preloaded value
        drv_en = 1'b1;
        run_to_frame_start();
        step();
        force dut.underflow_q = 16'hFFFE;
        m_uf = 16'hFFFE;
        #1;
        step();
        release dut.underflow_q;
        uf_inject = 3;
        repeat (20) step();
        check_eq("uf_sat", 32'(vif.underflow_cnt), 32'hFFFF);

        // asynchronous reset mid-line while running
        for (int k = 0; k < 2 * FT && !(m_v == 1 && m_h == 5); k++) step();
        #2;
        s_rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(negedge sclk);
        check_reset_outputs("held_rst");
        model_reset();
        s_rst_n = 1'b1;

        // after reset: IDLE, one waiting frame, then a full RUN frame
        drv_en = 1'b1;
        clear_obs();
        repeat (FT) step();
        check_eq("post_rst_wait_reads", 32'(rd_cnt), 32'd0);
        clear_obs();
        repeat (FT) step();
        check_eq("post_rst_run_reads", 32'(rd_cnt), 32'(HA * VA));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
